// File: rtl/gate_explorer_pkg.sv
// Shared definitions for the gate explorer: op encoding, FSM states and the
// per-bit logic op used by the result stage.
package gate_explorer_pkg;

  // Op select encoding as shown on the cur_sel indicator LEDs
  localparam logic [2:0] OP_NAND = 3'b000;
  localparam logic [2:0] OP_AND  = 3'b001;
  localparam logic [2:0] OP_NOR  = 3'b010;
  localparam logic [2:0] OP_OR   = 3'b011;
  localparam logic [2:0] OP_XOR  = 3'b100;
  localparam logic [2:0] OP_XNOR = 3'b101;
  localparam logic [2:0] OP_BUF  = 3'b110;
  localparam logic [2:0] OP_NOT  = 3'b111;

  // Select source: debounced switches or the auto-step sequencer
  typedef enum logic {
    ST_MANUAL = 1'b0,
    ST_AUTO   = 1'b1
  } state_t;

  // One bit of the selected logic op; y is ignored for BUF and NOT
  function automatic logic gate_bit(input logic [2:0] op,
                                    input logic       x,
                                    input logic       y);
    logic r;
    case (op)
      OP_NAND: r = ~(x & y);
      OP_AND:  r =   x & y;
      OP_NOR:  r = ~(x | y);
      OP_OR:   r =   x | y;
      OP_XOR:  r =   x ^ y;
      OP_XNOR: r = ~(x ^ y);
      OP_BUF:  r =   x;
      default: r =  ~x;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/gate_explorer_sel_debounce.sv
// Select-switch conditioning: 2-flop synchroniser followed by a hold-time
// debouncer. A value reaches stable only after it has been seen unchanged
// on DEBOUNCE_CYCLES+1 consecutive synchronised samples.
module sel_debounce #(
  parameter int W               = 3,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] raw,
  output logic [W-1:0] stable
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [W-1:0]     sync_p0;
  logic [W-1:0]     sync_p1;
  logic [W-1:0]     candidate;
  logic [CNT_W-1:0] cnt;

  // Bring the asynchronous switch value into the clock domain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw;
      sync_p1 <= sync_p0;
    end
  end

  // Restart the hold count on any change; commit once the count saturates
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      candidate <= '0;
      stable    <= '0;
      cnt       <= '0;
    end else if (sync_p1 != candidate) begin
      candidate <= sync_p1;
      cnt       <= '0;
    end else if (cnt == CNT_LAST) begin
      stable    <= candidate;
    end else begin
      cnt       <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gate_explorer.sv
// Gate explorer: applies one of eight bitwise logic ops to two switch
// operands and drives the registered result plus the active op to LEDs.
// The op comes from debounced select switches or, in auto mode, from a
// sequencer that advances one op every AUTO_DIV clocks.
module gate_explorer
  import gate_explorer_pkg::*;
#(
  parameter int WIDTH           = 1,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int AUTO_DIV        = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       sel_sw,
  input  logic             mode,
  output logic [WIDTH-1:0] result,
  output logic [2:0]       cur_sel,
  output logic             upd
);

  localparam int              PRE_W    = $clog2(AUTO_DIV);
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(AUTO_DIV - 1);

  logic [WIDTH-1:0] a_p0;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p0;
  logic [WIDTH-1:0] b_p1;
  logic             mode_p0;
  logic             mode_p1;
  logic [2:0]       stable;
  state_t           state;
  logic [PRE_W-1:0] presc;
  logic [WIDTH-1:0] op_out;

  // Stage p0/p1: 2-flop synchronisers for operands and mode switch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_p0    <= '0;
      a_p1    <= '0;
      b_p0    <= '0;
      b_p1    <= '0;
      mode_p0 <= 1'b0;
      mode_p1 <= 1'b0;
    end else begin
      a_p0    <= a;
      a_p1    <= a_p0;
      b_p0    <= b;
      b_p1    <= b_p0;
      mode_p0 <= mode;
      mode_p1 <= mode_p0;
    end
  end

  sel_debounce #(
    .W               (3),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_sel_debounce (
    .clk    (clk),
    .rst_n  (rst_n),
    .raw    (sel_sw),
    .stable (stable)
  );

  // Select sequencer: track stable in manual, step on prescaler wrap in auto.
  // A mode change takes priority over a coincident prescaler wrap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_MANUAL;
      presc   <= '0;
      cur_sel <= OP_NAND;
      upd     <= 1'b0;
    end else begin
      upd <= 1'b0;
      case (state)
        ST_MANUAL: begin
          cur_sel <= stable;
          upd     <= (stable != cur_sel);
          if (mode_p1) begin
            state <= ST_AUTO;
            presc <= '0;
          end
        end
        ST_AUTO: begin
          if (!mode_p1) begin
            state <= ST_MANUAL;
          end else if (presc == PRE_LAST) begin
            presc   <= '0;
            cur_sel <= cur_sel + 3'd1;
            upd     <= 1'b1;
          end else begin
            presc   <= presc + PRE_W'(1);
          end
        end
        default: begin
          state <= ST_MANUAL;
        end
      endcase
    end
  end

  // Bitwise application of the currently selected op
  always_comb begin
    op_out = '0;
    for (int i = 0; i < WIDTH; i++) begin
      op_out[i] = gate_bit(cur_sel, a_p1[i], b_p1[i]);
    end
  end

  // Stage p2: result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result <= '0;
    end else begin
      result <= op_out;
    end
  end

endmodule
